// File: rtl/mem_access_unit.sv
// mem_access_unit: single-request initiator for a 512x16 synchronous data memory
//
// Optional feature macro: MAU_PERF_CNT_EN (adds saturating rd_cnt / wr_cnt outputs)
//
// Ports
//   clk       in   system clock, rising edge
//   rst_b     in   asynchronous reset, active-low
//   req       in   request, sampled only while ready=1
//   wr        in   1=write, 0=read, qualified by req
//   addr      in   word address, sampled at the accept edge
//   wdata     in   write data, sampled at the accept edge
//   ready     out  combinational, high only in IDLE
//   rdata     out  last completed read value
//   rvalid    out  one-cycle pulse when rdata is updated
//   done      out  one-cycle pulse when any read or write completes
//   rd_cnt    out  (MAU_PERF_CNT_EN) saturating count of completed reads
//   wr_cnt    out  (MAU_PERF_CNT_EN) saturating count of completed writes
//   mem_we    out  memory write enable, registered
//   mem_addr  out  memory address, registered
//   mem_din   out  memory write data, registered
//   mem_dout  in   memory read data, registered inside the memory
module mem_access_unit #(
    parameter int AW = 9,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          req,
    input  logic          wr,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic          ready,
    output logic [DW-1:0] rdata,
    output logic          rvalid,
    output logic          done,
`ifdef MAU_PERF_CNT_EN
    output logic [15:0]   rd_cnt,
    output logic [15:0]   wr_cnt,
`endif
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] WR       = 2'd1;
    localparam logic [1:0] RD_ISSUE = 2'd2;
    localparam logic [1:0] RD_CAP   = 2'd3;

    logic [1:0] state;
    logic [1:0] state_nxt;

    assign ready = (state == IDLE);

    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:     state_nxt = req ? (wr ? WR : RD_ISSUE) : IDLE;
            RD_ISSUE: state_nxt = RD_CAP;
            default:  state_nxt = IDLE;
        endcase
    end

    // mem_we, rvalid and done default low every cycle, so each is a single-cycle
    // pulse; mem_we can only rise from IDLE, which keeps it from ever being high
    // in two consecutive cycles.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state    <= IDLE;
            rdata    <= '0;
            rvalid   <= 1'b0;
            done     <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
        end else begin
            state  <= state_nxt;
            rvalid <= 1'b0;
            done   <= 1'b0;
            mem_we <= 1'b0;
            case (state)
                IDLE: if (req) begin
                    mem_addr <= addr;
                    if (wr) begin
                        mem_we  <= 1'b1;
                        mem_din <= wdata;
                    end
                end
                WR: done <= 1'b1;
                RD_CAP: begin
                    // memory registered dout during RD_ISSUE; capture it now
                    rdata  <= mem_dout;
                    rvalid <= 1'b1;
                    done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef MAU_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            rd_cnt <= '0;
            wr_cnt <= '0;
        end else begin
            if (state == RD_CAP && rd_cnt != 16'hFFFF) rd_cnt <= rd_cnt + 16'd1;
            if (state == WR && wr_cnt != 16'hFFFF) wr_cnt <= wr_cnt + 16'd1;
        end
    end
`endif

endmodule
